// File: rtl/t_latch_bank.sv
// NCH-channel bank of WIDTH-bit transparent-mux latches with a global freeze.
// A snap strobe copies all channel outputs into a shadow bank, which is then streamed
// out one channel per valid/ready beat.
module t_latch_bank #(
  parameter int unsigned      WIDTH   = 16,
  parameter int unsigned      NCH     = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int unsigned     CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       en,
  input  logic                 freeze,
  input  logic [NCH*WIDTH-1:0] d,
  output logic [NCH*WIDTH-1:0] q,
  input  logic                 snap,
  input  logic                 clr_ovr,
  output logic                 busy,
  output logic [WIDTH-1:0]     rd_data,
  output logic [CW-1:0]        rd_ch,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 overrun
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  localparam logic [CW-1:0] LastCh = CW'(NCH - 1);

  logic [NCH-1:0]   open_ch;
  logic [WIDTH-1:0] q_ch     [NCH];
  logic [WIDTH-1:0] latch_q  [NCH];
  logic [WIDTH-1:0] shadow_q [NCH];

  state_e        state_q;
  logic          busy_q;
  logic          rd_valid_q;
  logic          overrun_q;
  logic [CW-1:0] rd_ch_q;

  logic snap_take;
  logic snap_drop;
  logic beat_acc;
  logic last_beat;

  assign open_ch = en & {NCH{~freeze}};

  // Zero-latency path when a channel is open; otherwise the held word.
  always_comb begin
    q = '0;
    for (int i = 0; i < NCH; i++) begin
      q_ch[i] = open_ch[i] ? d[i*WIDTH +: WIDTH] : latch_q[i];
      q[i*WIDTH +: WIDTH] = q_ch[i];
    end
  end

  assign snap_take = snap && (state_q == StIdle);
  assign snap_drop = snap && busy_q;
  assign beat_acc  = rd_valid_q && rd_ready;
  assign last_beat = (rd_ch_q == LastCh);

  // Shadow captures the post-mux value so the readback matches what q showed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        latch_q[i]  <= RST_VAL;
        shadow_q[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (open_ch[i]) begin
          latch_q[i] <= d[i*WIDTH +: WIDTH];
        end
        if (snap_take) begin
          shadow_q[i] <= q_ch[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_ch_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      // A new drop wins over a simultaneous clear.
      if (snap_drop) begin
        overrun_q <= 1'b1;
      end else if (clr_ovr) begin
        overrun_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (snap) begin
            state_q    <= StSend;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b1;
            rd_ch_q    <= '0;
          end
        end
        StSend: begin
          if (beat_acc) begin
            if (last_beat) begin
              state_q    <= StIdle;
              busy_q     <= 1'b0;
              rd_valid_q <= 1'b0;
            end else begin
              rd_ch_q <= rd_ch_q + 1'b1;
            end
          end
        end
        default: begin
          state_q    <= StIdle;
          busy_q     <= 1'b0;
          rd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign rd_valid = rd_valid_q;
  assign rd_ch    = rd_ch_q;
  assign rd_data  = shadow_q[rd_ch_q];
  assign overrun  = overrun_q;

endmodule
